// File: rtl/key_pkg.sv
// Shared definitions for the front-panel key path: FSM state encoding and
// key polarity constants, which are also used by keyDebouncing users.
package key_pkg;

    // Debounced key level is active-low.
    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    // Classifier state encoding.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } keyState_t;

    // Larger of two interval lengths, used to size the shared hold counter.
    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_hold_timer.sv
// Clearable up-counter with a terminal-count compare. The terminal value is
// an input so the same counter times both the long-press and repeat intervals.
// On reaching the terminal value while enabled it reloads to zero, so the count
// is always bounded by the active terminal value and never wraps.
module key_hold_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tcValue,
    output logic             tcHit
);

    logic [CNT_W-1:0] count;

    assign tcHit = (count == tcValue);

    // Count enabled edges; clear has priority, terminal count reloads to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (tcHit) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_press_classifier.sv
// Turns the debounced active-low key level into single-cycle press, release,
// short-press, long-press and (optionally) auto-repeat events, plus a held level.
//
// Optional feature macro: KEY_REPEAT_EN
//   defined   -> repeatPulse fires every REPEAT_CYCLES edges while long-held
//   undefined -> repeatPulse stays 0 and the counter idles in LONG_HELD
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | key released, counter held at zero, waiting for a press edge
// PRESSED   | key down, counting towards the long-press threshold
// LONG_HELD | long press reached, counting repeat intervals (if enabled)
module key_press_classifier
    import key_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic keyIn,
    output logic pressPulse,
    output logic releasePulse,
    output logic shortPress,
    output logic longPress,
    output logic repeatPulse,
    output logic keyHeld
);

    localparam int CNT_W = $clog2(maxInt(LONG_CYCLES, REPEAT_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

`ifdef KEY_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    keyState_t        state;
    logic             keyQ;
    logic             pressEdge;
    logic             releaseEdge;
    logic             timerClr;
    logic             timerEn;
    logic [CNT_W-1:0] timerTc;
    logic             timerHit;

    // keyQ resets to released, so a key already down at reset release is
    // seen as a fresh press on the first edge.
    assign pressEdge   = (keyIn == KEY_PRESSED)  && (keyQ == KEY_RELEASED);
    assign releaseEdge = (keyIn == KEY_RELEASED) && (keyQ == KEY_PRESSED);

    // Select the interval being timed and when the counter runs or clears.
    always_comb begin
        timerClr = 1'b0;
        timerEn  = 1'b0;
        timerTc  = LONG_TC;
        case (state)
            IDLE: begin
                timerClr = 1'b1;
            end
            PRESSED: begin
                if (releaseEdge) begin
                    timerClr = 1'b1;
                end else begin
                    timerEn = 1'b1;
                end
            end
            LONG_HELD: begin
                timerTc = REPEAT_TC;
                if (releaseEdge) begin
                    timerClr = 1'b1;
                end else begin
                    timerEn = REPEAT_ON;
                end
            end
            default: begin
                timerClr = 1'b1;
            end
        endcase
    end

    key_hold_timer #(
        .CNT_W (CNT_W)
    ) u_holdTimer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timerClr),
        .en      (timerEn),
        .tcValue (timerTc),
        .tcHit   (timerHit)
    );

    // Classifier FSM with registered event pulses and held level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            keyQ         <= KEY_RELEASED;
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
            shortPress   <= 1'b0;
            longPress    <= 1'b0;
            repeatPulse  <= 1'b0;
            keyHeld      <= 1'b0;
        end else begin
            keyQ         <= keyIn;
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
            shortPress   <= 1'b0;
            longPress    <= 1'b0;
            repeatPulse  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressEdge) begin
                        pressPulse <= 1'b1;
                        keyHeld    <= 1'b1;
                        state      <= PRESSED;
                    end
                end
                PRESSED: begin
                    // A release on the threshold edge wins over the long press.
                    if (releaseEdge) begin
                        releasePulse <= 1'b1;
                        shortPress   <= 1'b1;
                        keyHeld      <= 1'b0;
                        state        <= IDLE;
                    end else if (timerHit) begin
                        longPress <= 1'b1;
                        state     <= LONG_HELD;
                    end
                end
                LONG_HELD: begin
                    if (releaseEdge) begin
                        releasePulse <= 1'b1;
                        keyHeld      <= 1'b0;
                        state        <= IDLE;
                    end else if (REPEAT_ON && timerHit) begin
                        repeatPulse <= 1'b1;
                    end
                end
                default: begin
                    keyHeld <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_press_classifier.sv
// Scoreboard bench for key_press_classifier with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Repeat expectations are included only when KEY_REPEAT_EN is defined.
module tb_key_press_classifier;

    localparam int L = 8;
    localparam int R = 4;

    // Pulse vector order: {press, release, short, long, repeat}
    localparam logic [4:0] EV_PRESS  = 5'b10000;
    localparam logic [4:0] EV_REL    = 5'b01000;
    localparam logic [4:0] EV_SHORT  = 5'b00100;
    localparam logic [4:0] EV_LONG   = 5'b00010;
    localparam logic [4:0] EV_REPEAT = 5'b00001;

    typedef struct {
        int         expEdge;
        logic [4:0] vec;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic keyIn = 1'b1;
    logic pressPulse, releasePulse, shortPress, longPress, repeatPulse, keyHeld;

    int   edgeNum = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbQ[$];

    key_press_classifier #(
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .keyIn        (keyIn),
        .pressPulse   (pressPulse),
        .releasePulse (releasePulse),
        .shortPress   (shortPress),
        .longPress    (longPress),
        .repeatPulse  (repeatPulse),
        .keyHeld      (keyHeld)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeNum <= edgeNum + 1;

    task automatic expectEv(input int e, input logic [4:0] v, input string name);
        exp_t x;
        x.expEdge = e;
        x.vec     = v;
        x.name    = name;
        sbQ.push_back(x);
    endtask

    // Drive v for n sampling edges; entered and left at a falling edge.
    task automatic hold(input logic v, input int n);
        keyIn = v;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkHeld(input logic want, input string name);
        checks++;
        if (keyHeld !== want) begin
            errors++;
            $display("FAIL %s: keyHeld got %b required %b (edge %0d)", name, keyHeld, want, edgeNum);
        end
    endtask

    task automatic checkAllZero(input string name);
        logic [5:0] got;
        got = {pressPulse, releasePulse, shortPress, longPress, repeatPulse, keyHeld};
        checks++;
        if (got !== 6'b0) begin
            errors++;
            $display("FAIL %s: outputs got %b required 000000", name, got);
        end
    endtask

    // Monitor: every cycle with any pulse high must match the next expected event.
    always @(negedge clk) begin
        logic [4:0] got;
        exp_t       x;
        got = {pressPulse, releasePulse, shortPress, longPress, repeatPulse};
        if (!rst && got != 5'b0) begin
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got %b at edge %0d, required no pulse", got, edgeNum);
            end else begin
                x = sbQ.pop_front();
                if (x.vec !== got || x.expEdge != edgeNum) begin
                    errors++;
                    $display("FAIL %s: got %b at edge %0d, required %b at edge %0d",
                             x.name, got, edgeNum, x.vec, x.expEdge);
                end
            end
        end
    end

    initial begin
        int p;

        // Reset state
        repeat (3) @(negedge clk);
        checkAllZero("reset_outputs");
        rst = 1'b0;

        // 1: idle key produces nothing
        hold(1'b1, 20);
        checkHeld(1'b0, "idle_held");

        // 2: short press of 3 edges
        p = edgeNum + 1;
        expectEv(p, EV_PRESS, "short3_press");
        expectEv(p + 3, EV_REL | EV_SHORT, "short3_release");
        hold(1'b0, 3);
        checkHeld(1'b1, "short3_held");
        hold(1'b1, 5);
        checkHeld(1'b0, "short3_released");

        // 3a: release on the threshold edge -> short, no long
        p = edgeNum + 1;
        expectEv(p, EV_PRESS, "edge8_press");
        expectEv(p + 8, EV_REL | EV_SHORT, "edge8_release_wins");
        hold(1'b0, 8);
        hold(1'b1, 5);

        // 3b: held 9 edges -> long at P+8, plain release
        p = edgeNum + 1;
        expectEv(p, EV_PRESS, "long9_press");
        expectEv(p + 8, EV_LONG, "long9_long");
        expectEv(p + 9, EV_REL, "long9_release");
        hold(1'b0, 9);
        checkHeld(1'b1, "long9_held");
        hold(1'b1, 5);
        checkHeld(1'b0, "long9_released");

        // 4: long hold with repeats at P+12, P+16, P+20 (release at P+21)
        p = edgeNum + 1;
        expectEv(p, EV_PRESS, "rep_press");
        expectEv(p + 8, EV_LONG, "rep_long");
`ifdef KEY_REPEAT_EN
        expectEv(p + 12, EV_REPEAT, "rep_1");
        expectEv(p + 16, EV_REPEAT, "rep_2");
        expectEv(p + 20, EV_REPEAT, "rep_3");
`endif
        expectEv(p + 21, EV_REL, "rep_release");
        hold(1'b0, 21);
        hold(1'b1, 5);

        // 5: reset mid-hold, key still down at deassert -> fresh press
        p = edgeNum + 1;
        expectEv(p, EV_PRESS, "rst_press");
        hold(1'b0, 5);
        rst = 1'b1;
        #1;
        checkAllZero("rst_midhold_clear");
        repeat (2) @(negedge clk);
        checkAllZero("rst_held_clear");
        rst = 1'b0;
        p = edgeNum + 1;
        expectEv(p, EV_PRESS, "rst_repress");
        expectEv(p + 3, EV_REL | EV_SHORT, "rst_release");
        hold(1'b0, 3);
        checkHeld(1'b1, "rst_repress_held");
        hold(1'b1, 5);

        // 6: rapid toggles
        for (int i = 0; i < 10; i++) begin
            p = edgeNum + 1;
            expectEv(p, EV_PRESS, "toggle_press");
            expectEv(p + 1, EV_REL | EV_SHORT, "toggle_release");
            hold(1'b0, 1);
            hold(1'b1, 1);
        end
        hold(1'b1, 10);
        checkHeld(1'b0, "final_held");

        // Every expected event must have been seen.
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d pending, first %s expected at edge %0d, required 0 pending",
                     sbQ.size(), sbQ[0].name, sbQ[0].expEdge);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
